// File: rtl/shift_pkg.sv
// Shift-type encodings shared by the shift arbiter and the ALU decode.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_PASS = 2'b00,
        SHIFT_SLL  = 2'b01,
        SHIFT_SRL  = 2'b10,
        SHIFT_SRA  = 2'b11
    } shift_type_e;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational log-stage barrel shifter; left shifts reuse the right-shift
// stages on a bit-reversed operand.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    localparam int SHAMT_W  = $clog2(WORD_SIZE)
) (
    input  logic [WORD_SIZE-1:0] i_src,
    input  shift_type_e          i_type,
    input  logic [SHAMT_W-1:0]   i_shamt,
    output logic [WORD_SIZE-1:0] o_res
);

    logic                 is_left;
    logic                 fill;
    logic [WORD_SIZE-1:0] src_rev;
    logic [WORD_SIZE-1:0] stage_out_rev;
    logic [WORD_SIZE-1:0] stage [0:SHAMT_W];

    assign is_left = (i_type == SHIFT_SLL);
    assign fill    = (i_type == SHIFT_SRA) && i_src[WORD_SIZE-1];

    genvar gi;
    generate
        for (gi = 0; gi < WORD_SIZE; gi++) begin : g_rev
            assign src_rev[gi]       = i_src[WORD_SIZE-1-gi];
            assign stage_out_rev[gi] = stage[SHAMT_W][WORD_SIZE-1-gi];
        end

        assign stage[0] = is_left ? src_rev : i_src;

        // Stage gi shifts right by 2**gi when shamt bit gi is set.
        for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
            assign stage[gi+1] = i_shamt[gi]
                ? {{(1 << gi){fill}}, stage[gi][WORD_SIZE-1:(1 << gi)]}
                : stage[gi];
        end
    endgenerate

    always_comb begin
        o_res = stage[SHAMT_W];
        if (i_type == SHIFT_PASS) begin
            o_res = i_src;
        end else if (is_left) begin
            o_res = stage_out_rev;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shared barrel shifter with a single
// result register. Define SHIFT_ARB_ROUND_ROBIN_EN for alternating priority.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    localparam int SHAMT_W  = $clog2(WORD_SIZE)
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic                 i_req0_valid,
    input  logic [WORD_SIZE-1:0] i_req0_src,
    input  logic [1:0]           i_req0_type,
    input  logic [SHAMT_W-1:0]   i_req0_shamt,
    input  logic                 i_req1_valid,
    input  logic [WORD_SIZE-1:0] i_req1_src,
    input  logic [1:0]           i_req1_type,
    input  logic [SHAMT_W-1:0]   i_req1_shamt,
    output logic                 o_req0_ready,
    output logic                 o_req1_ready,
    output logic                 o_res_valid,
    output logic [WORD_SIZE-1:0] o_res_data,
    output logic                 o_res_id,
    input  logic                 i_res_ready
);

    logic                 res_valid_q, res_valid_d;
    logic [WORD_SIZE-1:0] res_data_q, res_data_d;
    logic                 res_id_q, res_id_d;
    logic                 prio_sel;
    logic                 slot_free;
    logic                 grant1;
    logic                 xfer;
    logic [WORD_SIZE-1:0] sel_src;
    logic [1:0]           sel_type;
    logic [SHAMT_W-1:0]   sel_shamt;
    logic [WORD_SIZE-1:0] shift_res;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
    logic prio_q, prio_d;

    // Priority goes to whichever requester did not just transfer.
    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = !grant1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio_sel = prio_q;
`else
    assign prio_sel = 1'b0;
`endif

    assign slot_free    = !res_valid_q || i_res_ready;
    assign grant1       = i_req1_valid && (!i_req0_valid || prio_sel);
    assign o_req0_ready = !i_RST && slot_free && i_req0_valid && !grant1;
    assign o_req1_ready = !i_RST && slot_free && grant1;
    assign xfer         = o_req0_ready || o_req1_ready;

    assign sel_src   = grant1 ? i_req1_src   : i_req0_src;
    assign sel_type  = grant1 ? i_req1_type  : i_req0_type;
    assign sel_shamt = grant1 ? i_req1_shamt : i_req0_shamt;

    barrel_shifter #(
        .WORD_SIZE (WORD_SIZE)
    ) u_shifter (
        .i_src   (sel_src),
        .i_type  (shift_type_e'(sel_type)),
        .i_shamt (sel_shamt),
        .o_res   (shift_res)
    );

    // A new transfer overwrites the slot even when the old result is consumed
    // on the same edge.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        if (xfer) begin
            res_valid_d = 1'b1;
            res_data_d  = shift_res;
            res_id_d    = grant1;
        end else if (i_res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign o_res_valid = res_valid_q;
    assign o_res_data  = res_data_q;
    assign o_res_id    = res_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed corner cases, then random
// traffic against a transaction-level reference model.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_src, req1_src;
    logic [1:0]  req0_type, req1_type;
    logic [4:0]  req0_shamt, req1_shamt;
    logic        req0_ready, req1_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic        m_id    = 1'b0;
    logic        m_prio  = 1'b0;
    logic        acc0 = 1'b0, acc1 = 1'b0;

    shift_arbiter #(.WORD_SIZE(32)) dut (
        .i_CLK        (clk),
        .i_RST        (rst),
        .i_req0_valid (req0_valid),
        .i_req0_src   (req0_src),
        .i_req0_type  (req0_type),
        .i_req0_shamt (req0_shamt),
        .i_req1_valid (req1_valid),
        .i_req1_src   (req1_src),
        .i_req1_type  (req1_type),
        .i_req1_shamt (req1_shamt),
        .o_req0_ready (req0_ready),
        .o_req1_ready (req1_ready),
        .o_res_valid  (res_valid),
        .o_res_data   (res_data),
        .o_res_id     (res_id),
        .i_res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Shift semantics from plain arithmetic on 64-bit unsigned values.
    function automatic logic [31:0] ref_shift(input logic [31:0] src, input logic [1:0] t,
                                              input logic [4:0] sh);
        longint unsigned s, p, r;
        s = 64'(src);
        p = 64'd1 << sh;
        case (t)
            2'b00:   r = s;
            2'b01:   r = (s * p) % 64'h1_0000_0000;
            2'b10:   r = s / p;
            default: begin
                r = s / p;
                if (src[31]) r = r + (64'h1_0000_0000 - (64'h1_0000_0000 / p));
            end
        endcase
        return r[31:0];
    endfunction

    task automatic set_req(input int n, input logic v, input logic [31:0] s,
                           input logic [1:0] t, input logic [4:0] a);
        if (n == 0) begin
            req0_valid = v; req0_src = s; req0_type = t; req0_shamt = a;
        end else begin
            req1_valid = v; req1_src = s; req1_type = t; req1_shamt = a;
        end
    endtask

    // One clock cycle: inputs already applied (at negedge); checks readies
    // before the edge and the result register after it; ends on the negedge.
    task automatic step(input logic rr);
        logic slot, w1, e0, e1;
        res_ready = rr;
        #1;
        slot = !m_valid || rr;
        w1   = req1_valid && (!req0_valid || m_prio);
        e0   = slot && req0_valid && !w1;
        e1   = slot && req1_valid && w1;
        chk("req0_ready", 64'(req0_ready), 64'(e0));
        chk("req1_ready", 64'(req1_ready), 64'(e1));
        @(posedge clk);
        #1;
        if (e0 || e1) begin
            m_valid = 1'b1;
            m_data  = e1 ? ref_shift(req1_src, req1_type, req1_shamt)
                         : ref_shift(req0_src, req0_type, req0_shamt);
            m_id    = e1;
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            m_prio  = !e1;
`endif
        end else if (rr) begin
            m_valid = 1'b0;
        end
        acc0 = e0;
        acc1 = e1;
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("res_data", 64'(res_data), 64'(m_data));
        chk("res_id", 64'(res_id), 64'(m_id));
        $display("cyc t=%0t g0=%0b g1=%0b rr=%0b res v=%0b id=%0b data=%08h",
                 $time, e0, e1, rr, res_valid, res_id, res_data);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        res_ready = 1'b0;
        set_req(0, 1'b0, '0, 2'b00, '0);
        set_req(1, 1'b0, '0, 2'b00, '0);
        #3;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_ready0", 64'(req0_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Continuous contention with the consumer always ready
        set_req(0, 1'b1, 32'h0000_00F0, 2'b10, 5'd4);
        set_req(1, 1'b1, 32'h0000_0003, 2'b01, 5'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
            chk("contend_id", 64'(res_id), 64'(i % 2));
`else
            chk("contend_id", 64'(res_id), 64'd0);
`endif
        end

        // Single req0 arithmetic shift
        set_req(1, 1'b0, '0, 2'b00, '0);
        set_req(0, 1'b1, 32'h8000_0001, 2'b11, 5'd4);
        step(1'b1);
        chk("sra_valid", 64'(res_valid), 64'd1);
        chk("sra_data", 64'(res_data), 64'hF800_0000);
        chk("sra_id", 64'(res_id), 64'd0);

        // Boundary shifts
        set_req(0, 1'b1, 32'h0000_0001, 2'b01, 5'd31);
        step(1'b1);
        chk("sll31", 64'(res_data), 64'h8000_0000);
        set_req(0, 1'b1, 32'h8000_0000, 2'b10, 5'd31);
        step(1'b1);
        chk("srl31", 64'(res_data), 64'h0000_0001);
        set_req(0, 1'b1, 32'h1234_ABCD, 2'b00, 5'd7);
        step(1'b1);
        chk("pass7", 64'(res_data), 64'h1234_ABCD);

        // Backpressure: a pending result freezes everything for 3 cycles
        set_req(0, 1'b1, 32'h0000_0F00, 2'b10, 5'd8);
        step(1'b1);
        set_req(0, 1'b1, 32'h0000_0001, 2'b01, 5'd1);
        set_req(1, 1'b1, 32'h0000_0004, 2'b10, 5'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("stall_data", 64'(res_data), 64'h0000_000F);
            chk("stall_id", 64'(res_id), 64'd0);
            chk("stall_ready0", 64'(req0_ready), 64'd0);
            chk("stall_ready1", 64'(req1_ready), 64'd0);
        end
        step(1'b1);
        chk("release_valid", 64'(res_valid), 64'd1);
`ifdef SHIFT_ARB_ROUND_ROBIN_EN
        chk("release_id", 64'(res_id), 64'd1);
        chk("release_data", 64'(res_data), 64'h0000_0002);
`else
        chk("release_id", 64'(res_id), 64'd0);
        chk("release_data", 64'(res_data), 64'h0000_0002);
`endif

        // Asynchronous reset mid-cycle with a result held
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(res_valid), 64'd0);
        chk("arst_data", 64'(res_data), 64'd0);
        chk("arst_id", 64'(res_id), 64'd0);
        chk("arst_ready0", 64'(req0_ready), 64'd0);
        chk("arst_ready1", 64'(req1_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_prio = 1'b0;
        step(1'b1);
        chk("post_rst_grant", 64'(res_id), 64'd0);

        // Random traffic; un-granted requests are held stable
        for (int i = 0; i < 300; i++) begin
            if (!(req0_valid && !acc0)) begin
                set_req(0, $urandom_range(0, 3) != 0, $urandom,
                        2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            end
            if (!(req1_valid && !acc1)) begin
                set_req(1, $urandom_range(0, 3) != 0, $urandom,
                        2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            end
            step($urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
